// File: rtl/vsim_receive.sv
// Host-to-hardware beat source: polls the host, buffers beats in a small FIFO and
// presents them on a ready/enable dequeue port. The host call sits behind host_poll/host_beat.
module vsim_receive #(
  parameter int width         = 32,
  parameter int DEPTH         = 4,
  parameter int POLL_INTERVAL = 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             deq__ENA,
  output logic             deq__RDY,
  output logic [width-1:0] deq_v,
  output logic             deq_last,
  output logic             in_msg,
  output logic [31:0]      msg_count,
  // host_poll marks a cycle in which the host is called exactly once; host_beat is
  // that call's return value {valid, last, data[31:0]}, consumed on the same edge.
  output logic             host_poll,
  input  logic [33:0]      host_beat
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PC_W  = (POLL_INTERVAL > 1) ? $clog2(POLL_INTERVAL) : 1;

  localparam logic [CNT_W-1:0] FULL_CNT    = CNT_W'(DEPTH);
  localparam logic [PC_W-1:0]  POLL_RELOAD = PC_W'(POLL_INTERVAL - 1);

  logic [width:0]       fifo_mem [DEPTH];
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [PC_W-1:0]      poll_cnt_q, poll_cnt_d;
  logic                 in_msg_q, in_msg_d;
  logic [31:0]          msg_count_q, msg_count_d;
  logic                 push;
  logic                 pop;
  logic                 head_last;

  assign deq__RDY  = (count_q != '0);
  assign head_last = fifo_mem[rd_ptr_q][width];
  assign deq_v     = fifo_mem[rd_ptr_q][width-1:0];
  assign deq_last  = head_last;
  assign in_msg    = in_msg_q;
  assign msg_count = msg_count_q;

  // Space is judged on start-of-cycle count, so a same-cycle pop never enables a poll.
  assign host_poll = !RST && (poll_cnt_q == '0) && (count_q != FULL_CNT);
  assign push      = host_poll && host_beat[33];
  assign pop       = deq__ENA && deq__RDY;

  // NOTE: every variable gets its default first so no path through the block
  // leaves a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    poll_cnt_d  = poll_cnt_q;
    in_msg_d    = in_msg_q;
    msg_count_d = msg_count_q;

    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);

    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
      in_msg_d = !head_last;
      if (head_last) msg_count_d = msg_count_q + 32'd1;
    end

    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    // A full FIFO parks the counter at zero so the poll fires as soon as space opens.
    if (host_poll)               poll_cnt_d = POLL_RELOAD;
    else if (poll_cnt_q != '0)   poll_cnt_d = poll_cnt_q - PC_W'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of process ordering in simulation.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      poll_cnt_q  <= '0;
      in_msg_q    <= 1'b0;
      msg_count_q <= '0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      poll_cnt_q  <= poll_cnt_d;
      in_msg_q    <= in_msg_d;
      msg_count_q <= msg_count_d;
    end
  end

  // NOTE: storage is deliberately not reset; count gates every read, so stale
  // contents are never observed as valid and the array can map to plain RAM.
  always_ff @(posedge CLK) begin
    if (push) fifo_mem[wr_ptr_q] <= {host_beat[32], host_beat[width-1:0]};
  end

endmodule

// File: doc/vsim_receive.md
# vsim_receive

Host-to-hardware message source for Verilator/VCS simulation. It is the receive-side counterpart of the simulation send path. It polls the host through a DPI-C import, buffers returned beats in a small FIFO, and presents them to the design under test on a ready/enable dequeue interface. It sits at the simulation top level, feeding request messages from host software into the design's indication/request plumbing.

## Interface
- width, 32: data bits per beat; legal range 1..32.
- DEPTH, 4: FIFO entries; power of two, ≥2.
- POLL_INTERVAL, 1: cycles between host polls; ≥1. 1 means poll every cycle.
- CLK  input  1  clock; all state updates on posedge.
- RST  input  1  reset; synchronous, active-high.
- deq__ENA  input  1  consumer takes the head beat this cycle.
- deq__RDY  output  1  FIFO non-empty.
- deq$v  output  width  head beat data.
- deq$last  output  1  head beat is the final beat of its message.
- in_msg  output  1  a message has been partly dequeued (a non-last beat taken, last not yet taken).
- msg_count  output  32  number of completed messages dequeued; wraps modulo 2^32.

## Operation
- DPI import: `longint dpi_msgReceive_beat()`.
  - Bit 33 = valid. Bit 32 = last. Bits 31:0 = data; the low `width` bits are stored.
  - Valid=0 means no beat is available. The return value is then discarded.
- State: FIFO storage, rd_ptr/wr_ptr (log2 DEPTH bits, wrap naturally), count (0..DEPTH), poll_cnt (0..POLL_INTERVAL-1), in_msg, msg_count.
- Poll condition: `!RST && poll_cnt==0 && count!=DEPTH`, using register values at the start of the cycle.
  - A same-cycle dequeue does not open space for a poll in that cycle.
- Per cycle with a poll:
  - Call the DPI function exactly once, inside the posedge block.
  - If valid, write {last,data} at wr_ptr and advance wr_ptr.
  - Reload poll_cnt to POLL_INTERVAL-1.
- poll_cnt when not polling:
  - Decrements while nonzero.
  - Holds at 0 while the FIFO is full. The next poll then happens in the first cycle count<DEPTH.
- Dequeue occurs when deq__ENA && deq__RDY. It advances rd_ptr.
  - deq__ENA while deq__RDY=0 is ignored: no state change. The bench flags it as a protocol warning only.
- count update:
  - Push only: +1.
  - Pop only: −1.
  - Push and pop together: unchanged.
  - Neither: unchanged.
- in_msg update on dequeue:
  - Set if deq$last=0.
  - Clear if deq$last=1; msg_count increments at the same time.
- deq__RDY = (count!=0). deq$v and deq$last are driven directly from the entry at rd_ptr.
  - When empty, deq$v and deq$last hold the last-read slot contents and are don't-care.
- Reset (RST high at an edge):
  - count, rd_ptr, wr_ptr, poll_cnt, in_msg and msg_count go to 0.
  - No DPI call is made in any cycle where RST is high.
  - Buffered beats are discarded, including mid-message. Host-side message framing is not repaired.

## Timing
- Reset values: deq__RDY=0, in_msg=0, msg_count=0. deq$v and deq$last are undefined until the first write.
- Poll-to-output latency is 1 edge. A valid beat returned by a poll at edge N gives deq__RDY=1 after edge N, so it is dequeuable in cycle N+1.
- Throughput with POLL_INTERVAL=1 and an always-ready consumer is 1 beat per cycle sustained. This holds because pop and push in the same cycle keep count<DEPTH.
- Full FIFO: at most DEPTH beats in flight. Polling is suppressed until count<DEPTH, so no beat is lost.
- The first poll after reset deasserts is in the first cycle with RST=0.

## Test plan
- Reset, then the host stub supplies 3 beats {0x11,0x22,0x33(last)} with the consumer always enabled:
  - deq__RDY rises 1 cycle after the first poll.
  - Beats come out in order, one per cycle.
  - msg_count=1 and in_msg=0 at the end.
  - in_msg=1 after the first beat is taken.
- Consumer stalled with DEPTH=4 and the stub always valid:
  - Exactly 4 DPI calls are made, then none while full.
  - Enabling dequeue for 1 cycle causes exactly 1 further poll in the next cycle.
  - Data order is preserved across pointer wrap after 10 beats.
- POLL_INTERVAL=3 with the stub always valid: DPI calls occur on cycles 0,3,6,… after reset; measured throughput is 1/3.
- Stub returns valid=0 for 5 polls, then beat 0xABCD last: the FIFO stays empty for those 5 cycles, then deq$v=0xABCD and deq$last=1 are presented.
- width=8 with the stub returning data 0x1FF: deq$v=0xFF.
- Reset asserted with 2 beats buffered and in_msg=1:
  - The next cycle has deq__RDY=0, in_msg=0 and msg_count=0.
  - No DPI call occurs during the reset cycles.
  - deq__ENA is ignored while empty.
